// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader
//
// Host-side operand staging for a modular exponentiator. The host streams four
// OP_W-bit operands (msg, n, r mod n, r^2 mod n) one WORD_W word at a time,
// least-significant word first. Once all four are complete, a run command
// latches the exponent and pulses exp_start. The loader then waits for
// exp_done, captures exp_result and streams it back out word by word.
//
// Optional feature: define RSA_LOADER_TIMEOUT_EN to add a watchdog on the WAIT
// state. It adds the timeout_o port and a cycle counter limited by TIMEOUT_CYC.
// When the macro is undefined, WAIT persists until exp_done.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   wr_valid_i/wr_ready_o    operand word write handshake
//   wr_sel_i                 0 msg, 1 n, 2 rmodn, 3 r2modn
//   wr_data_i                operand word
//   cmd_valid_i/cmd_ready_o  run command handshake
//   cmd_exp_i                exponent for the run
//   exp_start_o              one-cycle start pulse to the exponentiator
//   exp_msg_o .. exp_r2modn_o  operand registers
//   exp_exp_o                latched exponent
//   exp_result_i, exp_done_i exponentiator result and completion
//   rd_valid_o/rd_ready_i    result word read handshake
//   rd_data_o, rd_last_o     result word, high on the final word
//   busy_o                   high outside IDLE
//   loaded_o                 per-operand complete mask
//   timeout_o                (RSA_LOADER_TIMEOUT_EN only) sticky watchdog flag

module rsa_operand_loader #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned OP_W        = 1024,
  parameter int unsigned TIMEOUT_CYC = 2097152
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [1:0]        wr_sel_i,
  input  logic [WORD_W-1:0] wr_data_i,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [15:0]       cmd_exp_i,

  output logic              exp_start_o,
  output logic [OP_W-1:0]   exp_msg_o,
  output logic [OP_W-1:0]   exp_n_o,
  output logic [OP_W-1:0]   exp_rmodn_o,
  output logic [OP_W-1:0]   exp_r2modn_o,
  output logic [15:0]       exp_exp_o,
  input  logic [OP_W-1:0]   exp_result_i,
  input  logic              exp_done_i,

  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_last_o,

  output logic              busy_o,
  output logic [3:0]        loaded_o
`ifdef RSA_LOADER_TIMEOUT_EN
  ,
  output logic              timeout_o
`endif
);

  localparam int unsigned NumWords = OP_W / WORD_W;
  localparam int unsigned CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NumWords - 1);

  // Reject configurations the shift-register datapath cannot represent.
  if ((OP_W % WORD_W) != 0 || NumWords < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("rsa_operand_loader: unsupported WORD_W/OP_W/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWait, StUnload} state_e;

  state_e            state_q;
  logic [OP_W-1:0]   op_q   [4];
  logic [CntW-1:0]   wcnt_q [4];
  logic [3:0]        loaded_q;
  logic [15:0]       exp_q;
  logic              start_q;
  logic [OP_W-1:0]   res_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [CntW-1:0]   rcnt_q;

`ifdef RSA_LOADER_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);
  logic [WdW-1:0]    wdog_q;
  logic              timeout_q;
`endif

  logic              all_loaded;
  logic              wr_fire;
  logic              cmd_fire;
  logic              rd_fire;
  logic [CntW-1:0]   wcnt_d;
  logic              wload_d;

  assign all_loaded  = (loaded_q == 4'hF);
  // A pending run command takes priority over a same-cycle operand write.
  assign wr_ready_o  = (state_q == StIdle) && !(cmd_valid_i && all_loaded);
  assign cmd_ready_o = (state_q == StIdle) && all_loaded;
  assign wr_fire     = wr_valid_i && wr_ready_o;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign rd_fire     = rd_valid_q && rd_ready_i;

  // Word counter of the selected operand. A loaded operand sits at count 0, so
  // its first new write naturally restarts at 1 and drops the loaded bit.
  always_comb begin
    wcnt_d  = wcnt_q[wr_sel_i] + CntW'(1);
    wload_d = 1'b0;
    if (wcnt_q[wr_sel_i] == LastIdx) begin
      wcnt_d  = '0;
      wload_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      for (int i = 0; i < 4; i++) begin
        op_q[i]   <= '0;
        wcnt_q[i] <= '0;
      end
      loaded_q   <= '0;
      exp_q      <= '0;
      start_q    <= 1'b0;
      res_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rcnt_q     <= '0;
`ifdef RSA_LOADER_TIMEOUT_EN
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;

      // Writes only land in IDLE, so operands are frozen for the whole run.
      if (wr_fire) begin
        op_q[wr_sel_i]     <= {wr_data_i, op_q[wr_sel_i][OP_W-1:WORD_W]};
        wcnt_q[wr_sel_i]   <= wcnt_d;
        loaded_q[wr_sel_i] <= wload_d;
      end

      unique case (state_q)
        StIdle: begin
          if (cmd_fire) begin
            exp_q   <= cmd_exp_i;
            start_q <= 1'b1;
            state_q <= StStart;
`ifdef RSA_LOADER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end

        // exp_done is deliberately not looked at here.
        StStart: begin
          state_q <= StWait;
`ifdef RSA_LOADER_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end

        StWait: begin
          if (exp_done_i) begin
            res_q      <= exp_result_i;
            rd_valid_q <= 1'b1;
            rd_last_q  <= 1'b0;
            rcnt_q     <= '0;
            state_q    <= StUnload;
          end
`ifdef RSA_LOADER_TIMEOUT_EN
          else if (wdog_q == WdLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            wdog_q <= wdog_q + WdW'(1);
          end
`endif
        end

        StUnload: begin
          if (rd_fire) begin
            res_q     <= {{WORD_W{1'b0}}, res_q[OP_W-1:WORD_W]};
            rcnt_q    <= rcnt_q + CntW'(1);
            rd_last_q <= ((rcnt_q + CntW'(1)) == LastIdx);
            if (rd_last_q) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign exp_start_o  = start_q;
  assign exp_msg_o    = op_q[0];
  assign exp_n_o      = op_q[1];
  assign exp_rmodn_o  = op_q[2];
  assign exp_r2modn_o = op_q[3];
  assign exp_exp_o    = exp_q;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = res_q[WORD_W-1:0];
  assign rd_last_o    = rd_last_q;
  assign busy_o       = (state_q != StIdle);
  assign loaded_o     = loaded_q;
`ifdef RSA_LOADER_TIMEOUT_EN
  assign timeout_o    = timeout_q;
`endif

endmodule

// File: doc/rsa_operand_loader.md
RSA_OPERAND_LOADER -- requirements
Module: rsa_operand_loader

Interface
REQ-001 Parameter WORD_W, default 32, host bus word width in bits.
REQ-002 Parameter OP_W, default 1024, operand width; OP_W/WORD_W = 32 words per operand.
REQ-003 Parameter TIMEOUT_CYC, default 2097152, watchdog limit in cycles (used only under REQ-031).
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 resetn  in  1  synchronous active-low reset.
REQ-007 wr_valid, wr_ready  in/out  1  host operand-word write handshake.
REQ-008 wr_sel  in  2  write target: 0 msg, 1 n, 2 rmodn, 3 r2modn.
REQ-009 wr_data  in  WORD_W  operand word, least-significant word first.
REQ-010 cmd_valid, cmd_ready  in/out  1  run-command handshake.
REQ-011 cmd_exp  in  16  exponent for the run.
REQ-012 exp_start  out  1  one-cycle start pulse to the exponentiator.
REQ-013 exp_msg, exp_n, exp_rmodn, exp_r2modn  out  OP_W  operand registers, driven directly.
REQ-014 exp_exp  out  16  latched exponent.
REQ-015 exp_result  in  OP_W, and exp_done  in  1  exponentiator result and completion.
REQ-016 rd_valid, rd_ready  out/in  1  result-word read handshake; rd_data  out  WORD_W; rd_last  out  1.
REQ-017 busy  out  1  high in every state except IDLE; loaded  out  4  per-operand complete mask.

Function
REQ-018 FSM states SHALL be IDLE, START, WAIT, UNLOAD.
REQ-019 wr_ready = (state==IDLE) and not (cmd_valid and loaded==4'hF).
- cmd wins over a same-cycle write.
REQ-020 Write accept (wr_valid&wr_ready) SHALL shift the selected operand right one word, with wr_data entering bits [OP_W-1:OP_W-WORD_W].
- Increments that operand's 5-bit word counter.
REQ-021 On the 32nd accepted word the counter SHALL wrap to 0 and the loaded bit SHALL be set.
- The first write to an operand whose loaded bit is set SHALL clear that bit and restart counting.
REQ-022 cmd_ready = (state==IDLE) and (loaded==4'hF).
- cmd_valid with an incomplete mask SHALL stall; no side effect.
REQ-023 On cmd accept in cycle N: exp_exp <= cmd_exp, state -> START.
- exp_start SHALL be high exactly in cycle N+1, then state -> WAIT.
REQ-024 During START/WAIT/UNLOAD all exp_* operand outputs SHALL stay stable.
REQ-025 exp_done SHALL be ignored outside WAIT, including the START cycle.
REQ-026 First WAIT cycle M with exp_done high SHALL latch exp_result into the result shift register, and state -> UNLOAD.
- rd_valid SHALL be high from cycle M+1.
REQ-027 In UNLOAD, rd_data = result[WORD_W-1:0].
- On rd_valid&rd_ready the register shifts right one word.
- rd_last SHALL be high on word 31 only.
- Accept of the last word -> IDLE with rd_valid low the next cycle.
REQ-028 rd_valid SHALL not drop while rd_ready is low (data held stable).
REQ-029 The loaded mask and operands SHALL persist across runs; re-run with only msg rewritten SHALL be permitted.

Reset
REQ-030 resetn low at a clock edge SHALL force all of the following, including mid-WAIT or mid-UNLOAD, with no pending pulse surviving:
- IDLE, loaded=0, all counters 0;
- exp_start=0, rd_valid=0, rd_last=0, busy=0;
- operand, exponent and result registers = 0;
- timeout=0.

Configuration
REQ-031 With macro RSA_LOADER_TIMEOUT_EN defined, a watchdog SHALL run as follows:
- Adds output timeout (1 bit).
- A cycle counter clears on entry to WAIT.
- If exp_done is not seen within TIMEOUT_CYC cycles, state -> IDLE and timeout is set sticky until reset or the next cmd accept.
REQ-032 Without the macro there SHALL be no timeout port and no counter; WAIT persists until exp_done.

Verification
REQ-033 Write 32 words to each sel (word k = k+1) -> loaded=4'hF; exp_n[31:0]=1; exp_n[1023:992]=32.
REQ-034 cmd_valid with loaded=4'h7 for 10 cycles -> cmd_ready=0, exp_start never high; write 32 r2modn words -> accepted the next cycle, exp_start the cycle after.
REQ-035 exp_done held high from before cmd -> ignored until WAIT; capture result=0x...0003_0002_0001 -> rd_data sequence 1,2,3..., rd_last on word 31.
REQ-036 rd_ready toggled 1,0,0,1 during UNLOAD -> rd_data unchanged across stall cycles, 32 words total, then busy=0.
REQ-037 resetn low for 1 cycle in WAIT -> next cycle busy=0, loaded=0, exp_msg=0; later exp_done ignored.
REQ-038 With RSA_LOADER_TIMEOUT_EN and TIMEOUT_CYC=16, no exp_done -> timeout=1 and IDLE after 16 WAIT cycles; next cmd clears timeout.
